// File: rtl/dfe_iq_serializer.sv
// dfe_iq_serializer: re-pairs the muxed I/Q sample stream, buffers the pairs and
// shifts each one out as a framed serial word, MSB first, with I before Q.
// Ports:
//   clk, rst_n          readout clock; asynchronous active-low reset
//   din, din_valid      signed sample and its qualifier, one sample per valid cycle
//   din_iq              1 = I sample, 0 = Q sample
//   enable              permits new serial frames to start
//   sdo, frame          serial data; frame is high on the first bit of each word
//   fifo_level          pairs currently buffered
//   overflow, sync_err  sticky flags: pair dropped on a full FIFO / Q without a pending I
module dfe_iq_serializer #(
  parameter int BW    = 21,
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BW-1:0] din,
  input  logic          din_valid,
  input  logic          din_iq,
  input  logic          enable,
  output logic          sdo,
  output logic          frame,
  output logic [LW-1:0] fifo_level,
  output logic          overflow,
  output logic          sync_err
);
  localparam int FW = 2 * BW;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FW);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t        state;
  logic [FW-1:0] sr;
  logic [FW-1:0] mem [DEPTH];
  logic [CW-1:0] bitcnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [BW-1:0] i_hold;
  logic          hold_vld;
  logic          last, full, pop, push, push_ok;
  always_comb begin
    last    = bitcnt == CW'(FW - 1);
    full    = count == LW'(DEPTH);
    // a new frame starts from idle or directly after the last bit of the current one
    pop     = enable && count != '0 && (state == IDLE || last);
    push    = din_valid && !din_iq && hold_vld;
    // a full FIFO still accepts a pair when the head leaves on the same edge
    push_ok = push && (!full || pop);
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {i_hold, din};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      bitcnt   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      i_hold   <= '0;
      hold_vld <= 1'b0;
      overflow <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      if (din_valid) begin
        if (din_iq) begin
          i_hold   <= din;
          hold_vld <= 1'b1;
        end else if (hold_vld) hold_vld <= 1'b0;
        else sync_err <= 1'b1;
      end
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push && !push_ok) overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + LW'(push_ok) - LW'(pop);
      if (pop) begin
        state  <= SHIFT;
        sr     <= mem[rd_ptr];
        bitcnt <= '0;
      end else if (state == SHIFT) begin
        if (last) begin
          state  <= IDLE;
          sr     <= '0;
          bitcnt <= '0;
        end else begin
          sr     <= {sr[FW-2:0], 1'b0};
          bitcnt <= bitcnt + CW'(1);
        end
      end
    end
  end
  assign sdo        = state == SHIFT && sr[FW-1];
  assign frame      = state == SHIFT && bitcnt == '0;
  assign fifo_level = count;
endmodule

// File: doc/dfe_iq_serializer.md
# dfe_iq_serializer

Output stage of the decimating DFE chain. It takes the time-multiplexed I/Q sample stream from the final CIC/2:1 mux stage, re-pairs I with Q, and buffers the pairs in a small FIFO. It then shifts each pair off-chip as a framed serial word, MSB first, I before Q. It runs on one fast readout clock so the serial link drains faster than the decimated sample rate.

## Interface
Parameters:
- BW, 21: sample width (matches DFE output, signed two's complement)
- DEPTH, 4: FIFO depth in I/Q pairs; power of two, ≥2
- LW, 3: FIFO_LEVEL width; must satisfy 2^LW > DEPTH

Ports:
- CLK  in  1  readout clock; all state on rising edge
- RES  in  1  asynchronous, active-low reset
- DIN  in  BW  signed sample from DFE output mux
- DIN_VALID  in  1  DIN/DIN_IQ qualify this cycle (one sample per asserted cycle)
- DIN_IQ  in  1  1 = I sample, 0 = Q sample
- ENABLE  in  1  permits new serial frames to start
- SDO  out  1  serial data, MSB first
- FRAME  out  1  high during the first bit of each frame
- FIFO_LEVEL  out  LW  pairs currently stored
- OVERFLOW  out  1  sticky: a completed pair was dropped because the FIFO was full
- SYNC_ERR  out  1  sticky: a Q arrived with no pending I

## Operation
- Pair assembly: I accepted → I_hold ← DIN, hold_vld ← 1. A second I before Q overwrites I_hold (no flag). A Q with hold_vld=1 forms pair {I_hold, DIN} (2·BW bits), pushes it, and clears hold_vld. A Q with hold_vld=0 is discarded and sets SYNC_ERR.
- FIFO: DEPTH entries of 2·BW bits, circular read/write pointers, registered count. If a push hits a full FIFO with no same-cycle pop, the pair is dropped, OVERFLOW is set, and the FIFO contents are unchanged. A push and a pop in the same cycle are both honoured, including when full (level unchanged).
- Serializer FSM, 2 states:
  - IDLE: SDO=0, FRAME=0. If ENABLE=1 and level>0: pop the head into shift register SR and go to SHIFT with bitcnt=0.
  - SHIFT: SDO=SR[2·BW−1], FRAME=(bitcnt==0). Each cycle SR shifts left with zero fill and bitcnt increments.
  - At bitcnt=2·BW−1: if ENABLE=1 and level>0, pop the next pair into SR with bitcnt=0 (back-to-back, no gap bit). Otherwise go to IDLE.
- ENABLE deasserted mid-frame: the current frame completes; no new frame starts.
- Flags clear only on reset.
- Reset (RES=0, async): FSM=IDLE, SR=0, bitcnt=0, pointers/count=0, hold_vld=0, I_hold=0. SDO=0, FRAME=0, FIFO_LEVEL=0, OVERFLOW=0, SYNC_ERR=0. Reset mid-frame aborts the frame immediately and loses all buffered data. Deassertion is sampled by the next rising edge.

## Timing
- Q completing a pair accepted at edge t: FIFO_LEVEL increments after t.
- Serializer idle with ENABLE=1: pop at edge t+1. From t+1 onward FRAME=1 and SDO=I[BW−1].
- A frame occupies exactly 2·BW cycles: bits I[BW−1..0], then Q[BW−1..0].
- Back-to-back frames: next FRAME pulse occurs in the cycle directly after the previous frame's last bit.
- FIFO_LEVEL reflects the registered count, updated at the edge of a push or pop.
- OVERFLOW and SYNC_ERR assert in the cycle after the offending edge.
- Throughput requirement: the readout clock must give ≥2·BW cycles per input pair, otherwise the FIFO fills.

## Test plan
- Basic frame: reset, ENABLE=1, I=0x0ABCDE, then Q=0x154321 → FRAME one cycle at t+1. SDO over 42 cycles = 0x0ABCDE then 0x154321, MSB first. Then IDLE, SDO=0.
- Sign/extremes: I=−1 (all ones), Q=−2^20 → SDO = 21 ones, then 1 followed by 20 zeros.
- Back-to-back: 3 pairs queued with ENABLE=0, FIFO_LEVEL=3; raise ENABLE → 126 contiguous bits, FRAME at offsets 0, 42, 84; FIFO_LEVEL steps 2,1,0.
- Overflow/simultaneous: ENABLE=0, push 5 pairs → FIFO_LEVEL=4, OVERFLOW=1, output holds pairs 1–4. Repeat with full FIFO and a push on the same edge as a pop → level stays 4, OVERFLOW stays 0.
- Sync errors: Q alone → SYNC_ERR=1, nothing pushed. Sequence I=1, I=2, Q=3 → single frame {2,3}.
- Reset mid-frame: assert RES=0 at bit 10 with 2 pairs queued → SDO/FRAME/level/flags 0 immediately. After release with no input, SDO stays 0 and FRAME never pulses.
